cp0_unit: RTL
=============

Name: cp0_unit

Overview:
- Coprocessor-0 for the P7 pipeline; sits in the M stage beside the data-memory bridge.
- Holds SR, Cause and EPC.
- Arbitrates hardware interrupts and synchronous exceptions for the instruction currently in M.
- Drives `req`, which flushes the M/W register to the handler PC, and supplies EPC to the fetch mux for `eret`.

Parameters:
- HANDLER_PC, 32'h0000_4180, exception entry address (exported for the fetch mux and pipeline registers).
- HW_INT_W, 6, number of hardware interrupt lines (Cause.IP / SR.IM width).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- we  in  1  mtc0 write strobe from the M-stage instruction
- cp0_addr  in  5  CP0 register number (rd field)
- cp0_wdata  in  32  mtc0 data (forwarded rt)
- cp0_rdata  out  32  mfc0 read data, combinational
- pc_m  in  32  PC of the M-stage slot (bubbles carry a valid PC)
- bd_m  in  1  M-stage instruction is in a branch delay slot
- exc_valid  in  1  synchronous exception detected for the M-stage instruction
- exc_code_in  in  5  ExcCode of that exception
- eret_m  in  1  eret in M
- hw_int  in  6  external interrupt lines, level-sensitive
- req  out  1  take exception/interrupt this cycle
- epc_out  out  32  EPC for eret redirect

Behaviour:
- Registers:
  - SR(12): IM[15:10], EXL[1], IE[0].
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2].
  - EPC(14): 32 bits.
  - Unlisted bits read 0. Reads of unimplemented addresses return 0.
- Reset: SR, Cause, EPC all 0. `req` = 0 while reset is high.
- `int_req` = |(hw_int & SR.IM) & SR.IE & ~SR.EXL.
- `exc_req` = exc_valid & ~SR.EXL.
- `req` = (int_req | exc_req) & ~reset. Combinational, same cycle as M instruction.
- Interrupt priority: above synchronous exceptions.
- On posedge with `req`:
  - EXL<=1.
  - Cause.BD<=bd_m.
  - ExcCode<= int_req ? 0 : exc_code_in.
  - EPC<= bd_m ? pc_m-4 : pc_m.
  - Any concurrent mtc0 or eret effect is discarded.
- Cause.IP <= hw_int every non-reset cycle, independent of masking.
- eret (no req): EXL<=0 at that edge.
- mtc0 (we, no req):
  - addr 12 writes IM, EXL, IE.
  - addr 14 writes EPC with bits[1:0] forced 0.
  - addr 13 and others ignored.
- mfc0 reads current register state. No internal write-through.
- epc_out bypass: if we && cp0_addr==14 this cycle, epc_out = cp0_wdata & ~3; otherwise EPC. This covers mtc0 EPC immediately followed by eret.
- Latency: register updates visible one cycle after the edge. `req` is zero-latency.
- Boundaries:
  - Nested events while EXL=1 are all masked.
  - hw_int pulse shorter than one cycle while masked is lost; IP only mirrors the current level.
  - Reset mid-handler clears EXL.

Optional Feature:
- Macro: `CP0_BADVADDR_EN`.
- When defined:
  - Adds input `badvaddr_in` [31:0] and register BadVAddr(8), reset 0, readable at addr 8.
  - On exc_req with ExcCode 4 (AdEL) or 5 (AdES), and no int_req, BadVAddr<=badvaddr_in. Otherwise it holds.
  - For AdEL on fetch, upstream drives badvaddr_in = pc_m.
- When undefined: no port, addr 8 reads 0.

Decomposition:
- Shared constants file:
  - CP0 register numbers (SR=12, CAUSE=13, EPC=14, BADVADDR=8).
  - ExcCodes: INT=0, ADEL=4, ADES=5, SYSCALL=8, RI=10, OV=12.
  - HANDLER_PC and field bit positions.
- No sub-module needed. Interrupt/exception arbitration stays inline as a small combinational block.

Test Plan:
- Reset: assert reset with hw_int=6'h3F -> req=0; after release all reads = 0.
- mtc0 SR=32'h0000_FC01, then hw_int=6'b000100 with pc_m=32'h0000_3010, bd_m=0 -> req=1 same cycle; next cycle EPC=32'h3010, Cause=32'h0000_1000, SR.EXL=1.
- exc_valid=1, exc_code_in=12, bd_m=1, pc_m=32'h0000_3024, SR.EXL=0 -> req=1; EPC=32'h3020, Cause.BD=1, ExcCode=12.
- EXL=1, then exc_valid=1 plus hw_int active -> req=0; eret_m=1 -> next cycle EXL=0 and the pending interrupt raises req.
- Same cycle: we=1, addr=14, wdata=32'h0000_3403, with eret_m=1 -> epc_out=32'h3400 that cycle; EPC=32'h3400 after the edge.
- Same cycle: mtc0 SR=0 while int_req -> req=1, SR keeps IM/IE, EXL=1. With CP0_BADVADDR_EN: AdES at badvaddr_in=32'h0000_0007 -> mfc0 $8 returns 7.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 constants for the P7 pipeline: register numbers, ExcCodes,
// handler entry address and register field positions.
package cp0_pkg;

  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_SR       = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  typedef enum logic [4:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  localparam int SR_IE_BIT    = 0;
  localparam int SR_EXL_BIT   = 1;
  localparam int SR_IM_LO     = 10;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_BD_BIT = 31;

  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor 0 (SR, Cause, EPC) with interrupt/exception arbitration for the
// M stage. Optional BadVAddr register is enabled by `CP0_BADVADDR_EN.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter int HW_INT_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [4:0]          cp0_addr,
  input  logic [31:0]         cp0_wdata,
  output logic [31:0]         cp0_rdata,
  input  logic [31:0]         pc_m,
  input  logic                bd_m,
  input  logic                exc_valid,
  input  logic [4:0]          exc_code_in,
  input  logic                eret_m,
  input  logic [HW_INT_W-1:0] hw_int,
`ifdef CP0_BADVADDR_EN
  input  logic [31:0]         badvaddr_in,
`endif
  output logic                req,
  output logic [31:0]         epc_out
);

  logic [HW_INT_W-1:0] sr_im;
  logic                sr_exl;
  logic                sr_ie;
  logic                cause_bd;
  logic [HW_INT_W-1:0] cause_ip;
  logic [4:0]          cause_exc;
  logic [31:0]         epc;
`ifdef CP0_BADVADDR_EN
  logic [31:0]         badvaddr;
`endif

  logic int_req;
  logic exc_req;
  logic epc_wr;

  // Interrupts outrank synchronous exceptions; EXL masks everything.
  assign int_req = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req = exc_valid & ~sr_exl;
  assign req     = (int_req | exc_req) & ~reset;

  // An mtc0 to EPC in the same cycle as eret must redirect to the new value.
  assign epc_wr  = we && (cp0_addr == REG_EPC);
  assign epc_out = epc_wr ? {cp0_wdata[31:2], 2'b00} : epc;

  // NOTE: every register below uses non-blocking assignments so all fields
  // sample the same pre-edge state (e.g. EXL used by int_req above).
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      cause_ip <= hw_int;
      if (req) begin
        sr_exl    <= 1'b1;
        cause_bd  <= bd_m;
        cause_exc <= int_req ? EXC_INT : exc_code_in;
        epc       <= bd_m ? (pc_m - 32'd4) : pc_m;
      end else begin
        if (eret_m) sr_exl <= 1'b0;
        if (we) begin
          if (cp0_addr == REG_SR) begin
            sr_im  <= cp0_wdata[SR_IM_LO +: HW_INT_W];
            sr_exl <= cp0_wdata[SR_EXL_BIT];
            sr_ie  <= cp0_wdata[SR_IE_BIT];
          end else if (cp0_addr == REG_EPC) begin
            epc <= {cp0_wdata[31:2], 2'b00};
          end
        end
      end
    end
  end

`ifdef CP0_BADVADDR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      badvaddr <= '0;
    end else if (exc_req && !int_req && is_addr_exc(exc_code_in)) begin
      badvaddr <= badvaddr_in;
    end
  end
`endif

  // NOTE: cp0_rdata gets a default before the case so no latch is inferred
  // for unimplemented addresses or unlisted bits.
  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      REG_SR: begin
        cp0_rdata[SR_IM_LO +: HW_INT_W] = sr_im;
        cp0_rdata[SR_EXL_BIT]           = sr_exl;
        cp0_rdata[SR_IE_BIT]            = sr_ie;
      end
      REG_CAUSE: begin
        cp0_rdata[CAUSE_BD_BIT]             = cause_bd;
        cp0_rdata[CAUSE_IP_LO +: HW_INT_W]  = cause_ip;
        cp0_rdata[CAUSE_EXC_LO +: 5]        = cause_exc;
      end
      REG_EPC: cp0_rdata = epc;
`ifdef CP0_BADVADDR_EN
      REG_BADVADDR: cp0_rdata = badvaddr;
`endif
      default: cp0_rdata = '0;
    endcase
  end

endmodule
